// File: rtl/schoolbook_unload_pkg.sv
// Shared sizing and state encoding for the schoolbook multiplier product path.
package schoolbook_unload_pkg;

    // Product of two 409-bit operands, streamed out in 32-bit words.
    localparam int SB_WIDTH  = 818;
    localparam int SB_WORD   = 32;
    localparam int SB_NWORDS = (SB_WIDTH + SB_WORD - 1) / SB_WORD;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sb_state_t;

endpackage

// File: rtl/schoolbook_unload.sv
// Captures a finished schoolbook product and streams it out LS word first
// over a valid/ready handshake. Products offered while busy are dropped and
// flagged on a sticky overrun bit.
module schoolbook_unload
    import schoolbook_unload_pkg::*;
#(
    parameter int WIDTH  = SB_WIDTH,
    parameter int WORD   = SB_WORD,
    parameter int NWORDS = SB_NWORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [WORD-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             overrun
);

    localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    sb_state_t                        state, state_nxt;
    logic [IDXW-1:0]                  idx, idx_nxt;
    logic [NWORDS-1:0][WORD-1:0]      cap;
    logic [NWORDS*WORD-1:0]           prod_ext;
    logic                             xfer;
    logic                             capture;

    // Upper bits of the last word are zero padding.
    assign prod_ext = (NWORDS*WORD)'(prod);

    // State and word index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Capture register; only loaded on an accepted product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cap <= '0;
        else if (capture)
            cap <= prod_ext;
    end

    // Sticky overrun: a product offered while we cannot take it is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            overrun <= 1'b0;
        else if (prod_valid && !prod_ready)
            overrun <= 1'b1;
    end

    // Handshake outputs and next-state logic. The last-word transfer also
    // opens prod_ready so a new product can follow with no bubble.
    always_comb begin
        out_valid  = (state == SEND);
        out_last   = (state == SEND) && (idx == LAST_IDX);
        out_data   = cap[idx];
        xfer       = out_valid && out_ready;
        prod_ready = (state == IDLE) || (xfer && out_last);
        capture    = prod_valid && prod_ready;
        state_nxt  = state;
        idx_nxt    = idx;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (out_last) begin
                        idx_nxt   = '0;
                        state_nxt = capture ? SEND : IDLE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_schoolbook_unload.sv
// Directed bench for schoolbook_unload: streaming, stalls, overrun,
// back-to-back products and asynchronous reset mid-stream.
module tb_schoolbook_unload;
    import schoolbook_unload_pkg::*;

    localparam int WIDTH  = SB_WIDTH;
    localparam int WORD   = SB_WORD;
    localparam int NWORDS = SB_NWORDS;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] prod = '0;
    logic             prod_valid = 1'b0;
    logic             prod_ready;
    logic [WORD-1:0]  out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             overrun;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0]      exp_w [NWORDS];
    logic [WIDTH-1:0] p_one, p_ones, p_pat;

    schoolbook_unload dut (
        .clk        (clk),
        .rst        (rst),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Hand-written expected words for the three reference products.
    task automatic load_exp(input int kind);
        for (int i = 0; i < NWORDS; i++) begin
            case (kind)
                0: exp_w[i] = (i == 0) ? 32'h0000_0001 : 32'h0000_0000;
                1: exp_w[i] = (i == 25) ? 32'h0003_FFFF : 32'hFFFF_FFFF;
                default: exp_w[i] = (i == 25) ? 32'h0002_0019 : (32'hC0DE_0000 | 32'(i));
            endcase
        end
    endtask

    // Offer a product at the next negedge; caller expects it to be taken.
    task automatic launch(input logic [WIDTH-1:0] p);
        @(negedge clk);
        prod       = p;
        prod_valid = 1'b1;
        out_ready  = 1'b1;
        #1;
        chk("launch_ready", 64'(prod_ready), 64'd1);
    endtask

    // Walk one product out of the block. ovr_at: index at which a second
    // product is offered (-1 none). rst_at: index at which reset is pulled
    // (-1 none). b2b: offer p2 alongside the last-word transfer.
    task automatic stream(input logic stall, input int ovr_at, input int rst_at,
                          input logic b2b, input logic [WIDTH-1:0] p2);
        int   idx = 0;
        int   cyc = 0;
        logic ovr_seen = 1'b0;
        logic stall_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (idx < NWORDS && cyc < 200) begin
            @(negedge clk);
            prod_valid = 1'b0;
            out_ready  = stall ? stall_pat[cyc % 4] : 1'b1;
            if (idx == ovr_at && !ovr_seen) begin
                prod       = p2;
                prod_valid = 1'b1;
            end
            if (b2b && idx == NWORDS-1) begin
                prod       = p2;
                prod_valid = 1'b1;
            end
            #1;
            chk($sformatf("valid_w%0d", idx), 64'(out_valid), 64'd1);
            chk($sformatf("data_w%0d", idx), 64'(out_data), 64'(exp_w[idx]));
            chk($sformatf("last_w%0d", idx), 64'(out_last), 64'(idx == NWORDS-1));
            chk($sformatf("ovr_w%0d", idx), 64'(overrun), 64'(ovr_seen));
            if (b2b && idx == NWORDS-1)
                chk("b2b_ready", 64'(prod_ready), 64'd1);
            if (idx == ovr_at)
                ovr_seen = 1'b1;
            if (idx == rst_at) begin
                #1 rst = 1'b0;
                #1;
                chk("arst_valid", 64'(out_valid), 64'd0);
                chk("arst_last", 64'(out_last), 64'd0);
                chk("arst_ovr", 64'(overrun), 64'd0);
                chk("arst_ready", 64'(prod_ready), 64'd1);
                return;
            end
            if (out_ready)
                idx++;
            cyc++;
        end
        chk("xfer_count", 64'(idx), 64'(NWORDS));
    endtask

    initial begin
        p_one  = WIDTH'(1);
        p_ones = '1;
        p_pat  = '0;
        for (int i = 0; i < NWORDS-1; i++)
            p_pat[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
        p_pat[817:800] = 18'h2_0019;

        // Reset state
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        chk("rst_ready", 64'(prod_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // prod = 1, full speed
        load_exp(0);
        launch(p_one);
        stream(1'b0, -1, -1, 1'b0, '0);
        @(negedge clk);
        prod_valid = 1'b0;
        #1;
        chk("idle_after_one", 64'(out_valid), 64'd0);

        // all ones, full speed
        load_exp(1);
        launch(p_ones);
        stream(1'b0, -1, -1, 1'b0, '0);

        // pattern with ready toggling 1,0,0,1
        load_exp(2);
        launch(p_pat);
        stream(1'b1, -1, -1, 1'b0, '0);

        // overrun at index 10; stream keeps first product
        load_exp(2);
        launch(p_pat);
        stream(1'b0, 10, -1, 1'b0, p_ones);
        @(negedge clk);
        prod_valid = 1'b0;
        #1;
        chk("ovr_sticky", 64'(overrun), 64'd1);
        chk("ovr_idle", 64'(out_valid), 64'd0);
        #1 rst = 1'b0;
        #1;
        chk("ovr_cleared", 64'(overrun), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // back-to-back: second product offered with the last-word transfer
        load_exp(0);
        launch(p_one);
        stream(1'b0, -1, -1, 1'b1, p_pat);
        load_exp(2);
        stream(1'b0, -1, -1, 1'b0, '0);

        // async reset at index 5, with an overrun raised earlier
        load_exp(2);
        launch(p_pat);
        stream(1'b0, 2, 5, 1'b0, p_one);
        prod_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_hold_valid", 64'(out_valid), 64'd0);
        // release and offer on the same negedge: first edge after release captures
        @(negedge clk);
        rst        = 1'b1;
        prod       = p_one;
        prod_valid = 1'b1;
        #1;
        chk("rel_valid", 64'(out_valid), 64'd0);
        chk("rel_ready", 64'(prod_ready), 64'd1);
        load_exp(0);
        stream(1'b0, -1, -1, 1'b0, '0);
        @(negedge clk);
        prod_valid = 1'b0;
        #1;
        chk("final_idle", 64'(out_valid), 64'd0);
        chk("final_ovr", 64'(overrun), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/schoolbook_unload.md
SCHOOLBOOK_UNLOAD -- requirements
Module: schoolbook_unload

Interface
REQ-001 Parameter WIDTH, default 818, product width in bits (2x409 operand).
REQ-002 Parameter WORD, default 32, output word width in bits.
REQ-003 Parameter NWORDS, default 26, ceil(WIDTH/WORD), number of output words.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 prod  input  WIDTH  product from the schoolbook multiplier.
REQ-007 prod_valid  input  1  one-cycle pulse: prod is final and stable this cycle.
REQ-008 prod_ready  output  1  block can capture a product this cycle.
REQ-009 out_data  output  WORD  current product word, least-significant word first.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_last  output  1  current word is word NWORDS-1.
REQ-013 overrun  output  1  sticky flag: a product was offered and dropped.

Function
REQ-014 The block SHALL implement two states: IDLE and SEND.
REQ-015 In IDLE, prod_ready SHALL be 1, out_valid 0, out_last 0.
REQ-016 A product SHALL be captured when prod_valid and prod_ready are both 1; the captured value SHALL be zero-extended to NWORDS*WORD bits.
REQ-017 Capture SHALL set state SEND and word index 0, so out_valid=1 with word 0 in the cycle after prod_valid (latency 1).
REQ-018 In SEND, out_data SHALL be bits [WORD*i+WORD-1 : WORD*i] of the captured product, with i = word index.
REQ-019 A word transfers when out_valid and out_ready are both 1; index SHALL increment by 1 per transfer and hold otherwise.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold unchanged.
REQ-021 out_last SHALL be 1 exactly when in SEND and index = NWORDS-1; with the defaults the last word SHALL carry prod[817:800] in bits [17:0] and zeros in bits [31:18].
REQ-022 Transfer of the last word SHALL return the block to IDLE and reset the index to 0; the index SHALL never exceed NWORDS-1.
REQ-023 In SEND, prod_ready SHALL be 1 only in a cycle where out_valid, out_ready and out_last are all 1; otherwise 0.
REQ-024 prod_valid in the same cycle as the last-word transfer SHALL be captured; the next cycle SHALL present word 0 of the new product with no idle cycle.
REQ-025 prod_valid while prod_ready=0 SHALL leave the in-flight product unchanged and set overrun to 1.
REQ-026 overrun SHALL remain 1 until reset.
REQ-027 Throughput with out_ready held at 1 SHALL be one word per cycle, i.e. NWORDS cycles per product.

Reset
REQ-028 Asserting rst=0 SHALL immediately force state to IDLE, index to 0, captured register to 0, overrun to 0, out_valid to 0 and out_last to 0, independent of clk.
REQ-029 Reset asserted mid-SEND SHALL abandon the current product; no further words of it SHALL appear after reset release.
REQ-030 The first capture SHALL be possible on the first rising edge after rst returns to 1.

Structure
REQ-031 A shared package SHALL hold WIDTH, WORD and NWORDS defaults and the IDLE/SEND state encoding, so the multiplier and this block use the same product width.
REQ-032 No sub-module SHALL be required; word selection SHALL be an indexed slice of the capture register, or a right-shift by WORD per transfer.
REQ-033 Index counter width SHALL be ceil(log2(NWORDS)) bits (5 for the defaults).

Verification
REQ-034 prod=1, prod_valid pulse, out_ready=1 -> 26 consecutive out_valid cycles; word0=0x00000001; words1..25=0; out_last only on word 25.
REQ-035 prod = all ones (818 bits), out_ready=1 -> words0..24=0xFFFFFFFF, word25=0x0003FFFF with out_last=1.
REQ-036 out_ready toggled 1,0,0,1 repeatedly -> data held stable during stalls; word order 0..25 preserved; exactly 26 transfers.
REQ-037 Second prod_valid at word index 10 -> overrun=1 and stays 1; streamed words still match the first product.
REQ-038 Second prod_valid in the same cycle as the word-25 transfer -> next cycle word0 of the second product, overrun=0.
REQ-039 rst=0 asynchronously at word index 5 -> out_valid=0 at once, overrun=0; after release and a new prod_valid, the stream restarts at word 0.
